// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame width, FSM state
// encoding and the even-parity helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous show-ahead FIFO. A push into a full FIFO is accepted
// only when a pop happens on the same edge; a pop on empty is ignored.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero while empty so the output is defined after reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver: two-flop synchronizer, mid-bit sampling FSM with optional
// even parity, error pulses, and a show-ahead output FIFO with valid/ready.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam int             BW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 rx_p0;
    logic                 rx_p1;
    logic                 rxs;
    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;
    logic [BW-1:0]        bit_idx;
    logic [BW-1:0]        bit_idx_nxt;
    logic                 par_bad;
    logic                 par_bad_nxt;
    logic                 shift_en;
    logic [DATA_BITS-1:0] data_sh;
    logic                 push_req;
    logic                 frame_err_nxt;
    logic                 parity_err_nxt;
    logic                 overrun_nxt;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Stage p0/p1: metastability filter on the asynchronous line, idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rxs  = rx_p1;
    assign busy = (state != ST_IDLE);

    // Frame sequencing: counter runs every cycle, sampling happens when it hits
    // the half-bit (start) or full-bit (all later bits) terminal count.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + CW'(1);
        bit_idx_nxt    = bit_idx;
        par_bad_nxt    = par_bad;
        shift_en       = 1'b0;
        push_req       = 1'b0;
        frame_err_nxt  = 1'b0;
        parity_err_nxt = 1'b0;
        overrun_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!rxs) begin
                    state_nxt   = ST_START;
                    bit_idx_nxt = '0;
                    par_bad_nxt = 1'b0;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    // A line already back high at mid-start was a glitch.
                    state_nxt = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt     = '0;
                    shift_en    = 1'b1;
                    bit_idx_nxt = bit_idx + BW'(1);
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt     = '0;
                    par_bad_nxt = (rxs != even_parity(data_sh));
                    state_nxt   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt = '0;
                    if (!rxs) begin
                        // Framing error outranks any parity error on this frame.
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_BREAK;
                    end else if (par_bad) begin
                        parity_err_nxt = 1'b1;
                        state_nxt      = ST_IDLE;
                    end else begin
                        push_req    = 1'b1;
                        overrun_nxt = fifo_full && !(ready && valid);
                        state_nxt   = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                cnt_nxt = '0;
                // Hold here until the line releases so a stuck-low line cannot retrigger.
                if (rxs) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control registers: FSM state, counters, latched parity result, pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            par_bad    <= par_bad_nxt;
            frame_err  <= frame_err_nxt;
            parity_err <= parity_err_nxt;
            overrun    <= overrun_nxt;
        end
    end

    // Data shifter, LSB arrives first so new bits enter at the top.
    always_ff @(posedge clk) begin
        if (shift_en) data_sh <= {rxs, data_sh[DATA_BITS-1:1]};
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (data_sh),
        .pop   (ready),
        .dout  (dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: one 8N1 instance and one even-parity instance,
// directed scenarios plus random frames checked against a frame-level model.
module tb_uart_rx_oversample;
    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic       ready0 = 1'b1;
    logic       ready1 = 1'b1;
    logic [7:0] dout0, dout1;
    logic       valid0, valid1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int         pop0_c[$], pop1_c[$];
    logic [7:0] pop0_d[$], pop1_d[$];
    int         fe0_q[$], pe0_q[$], ov0_q[$], fe1_q[$], pe1_q[$], ov1_q[$];
    bit         busy_log [65536];

    uart_rx_oversample #(.CLKS_PER_BIT(C), .PARITY_EN(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .dout(dout0), .valid(valid0), .ready(ready0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(busy0));

    uart_rx_oversample #(.CLKS_PER_BIT(C), .PARITY_EN(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .dout(dout1), .valid(valid1), .ready(ready1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(busy1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled on the inactive edge with cycle stamps.
    always @(negedge clk) begin
        busy_log[cyc % 65536] = busy0;
        if (valid0 && ready0) begin pop0_c.push_back(cyc); pop0_d.push_back(dout0); end
        if (valid1 && ready1) begin pop1_c.push_back(cyc); pop1_d.push_back(dout1); end
        if (fe0) fe0_q.push_back(cyc);
        if (pe0) pe0_q.push_back(cyc);
        if (ov0) ov0_q.push_back(cyc);
        if (fe1) fe1_q.push_back(cyc);
        if (pe1) pe1_q.push_back(cyc);
        if (ov1) ov1_q.push_back(cyc);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx0 = v; else rx1 = v;
    endtask

    // Drive one frame; pmode < 0 means no parity bit, else the parity bit value.
    // t returns the cycle in which the start bit appears on the pin.
    task automatic send(input int which, input logic [7:0] b, input int pmode,
                        input logic stopb, output int t);
        logic [10:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        if (pmode >= 0) begin
            bits[9] = pmode[0]; bits[10] = stopb; nb = 11;
        end else begin
            bits[9] = stopb; nb = 10;
        end
        t = cyc;
        for (int i = 0; i < nb; i++) begin
            set_rx(which, bits[i]);
            idle(C);
        end
    endtask

    task automatic clear_logs();
        pop0_c.delete(); pop0_d.delete(); pop1_c.delete(); pop1_d.delete();
        fe0_q.delete(); pe0_q.delete(); ov0_q.delete();
        fe1_q.delete(); pe1_q.delete(); ov1_q.delete();
    endtask

    initial begin
        int t, h, r;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        logic [7:0] model_fifo[$];
        int exp_fe, exp_pe, exp_ov;
        logic pgood, sgood, pbit;

        // Reset state
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(valid0), 0);
        check("rst_dout", 32'(dout0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_flags", {29'd0, fe0, pe0, ov0}, 0);
        check("rst_valid_p", 32'(valid1), 0);
        idle(1);
        clear_logs();

        // 0xA5 8N1: stop sample at start+2+8+144, byte visible the cycle after
        send(0, 8'hA5, -1, 1'b1, t);
        idle(5);
        check("a5_pops", pop0_d.size(), 1);
        if (pop0_d.size() > 0) begin
            check("a5_data", 32'(pop0_d[0]), 32'h A5);
            check("a5_time", pop0_c[0], t + 155);
        end
        check("a5_flags", fe0_q.size() + pe0_q.size() + ov0_q.size(), 0);
        check("a5_busy_end", 32'(busy_log[(t + 155) % 65536]), 0);
        check("a5_busy_mid", 32'(busy_log[(t + 100) % 65536]), 1);
        clear_logs();

        // 4-cycle glitch: false start detected at the mid-start sample
        t = cyc;
        rx0 = 1'b0;
        idle(4);
        rx0 = 1'b1;
        idle(2 * C);
        check("gl_busy_t0", 32'(busy_log[(t + 2) % 65536]), 0);
        check("gl_busy_t1", 32'(busy_log[(t + 3) % 65536]), 1);
        check("gl_busy_t8", 32'(busy_log[(t + 10) % 65536]), 1);
        check("gl_busy_t9", 32'(busy_log[(t + 11) % 65536]), 0);
        check("gl_nothing", pop0_d.size() + fe0_q.size() + pe0_q.size() + ov0_q.size(), 0);
        clear_logs();

        // Framing error, line held low, then recovery
        send(0, 8'h3C, -1, 1'b0, t);
        idle(40);
        h = cyc;
        rx0 = 1'b1;
        idle(C);
        check("br_fe_count", fe0_q.size(), 1);
        if (fe0_q.size() > 0) check("br_fe_time", fe0_q[0], t + 155);
        check("br_no_pop", pop0_d.size(), 0);
        check("br_busy_held", 32'(busy_log[(t + 175) % 65536]), 1);
        check("br_busy_rel2", 32'(busy_log[(h + 2) % 65536]), 1);
        check("br_busy_rel3", 32'(busy_log[(h + 3) % 65536]), 0);
        send(0, 8'h11, -1, 1'b1, t);
        idle(5);
        check("br_11_pops", pop0_d.size(), 1);
        if (pop0_d.size() > 0) check("br_11_data", 32'(pop0_d[0]), 32'h11);
        check("br_fe_once", fe0_q.size(), 1);
        clear_logs();

        // Parity instance: 0x07 has odd weight, so even parity bit must be 1
        send(1, 8'h07, 0, 1'b1, t);
        idle(5);
        check("par_pe_count", pe1_q.size(), 1);
        if (pe1_q.size() > 0) check("par_pe_time", pe1_q[0], t + 171);
        check("par_no_pop", pop1_d.size(), 0);
        send(1, 8'h07, 1, 1'b1, t);
        idle(5);
        check("par_ok_pops", pop1_d.size(), 1);
        if (pop1_d.size() > 0) begin
            check("par_ok_data", 32'(pop1_d[0]), 32'h07);
            check("par_ok_time", pop1_c[0], t + 171);
        end
        check("par_pe_once", pe1_q.size(), 1);
        clear_logs();

        // Overrun: consumer stalled, five back-to-back bytes into four entries
        ready0 = 1'b0;
        model_fifo.delete();
        exp_ov = 0;
        for (int k = 1; k <= 5; k++) begin
            b = 8'(k);
            if (model_fifo.size() < 4) model_fifo.push_back(b); else exp_ov++;
            send(0, b, -1, 1'b1, t);
        end
        idle(5);
        check("ov_count", ov0_q.size(), exp_ov);
        if (ov0_q.size() > 0) check("ov_time", ov0_q[0], t + 155);
        check("ov_no_pop", pop0_d.size(), 0);
        r = cyc;
        ready0 = 1'b1;
        idle(8);
        check("ov_pops", pop0_d.size(), model_fifo.size());
        for (int i = 0; i < pop0_d.size() && i < model_fifo.size(); i++) begin
            check($sformatf("ov_pop%0d_data", i), 32'(pop0_d[i]), 32'(model_fifo[i]));
            check($sformatf("ov_pop%0d_time", i), pop0_c[i], r + i);
        end
        check("ov_drained", 32'(valid0), 0);
        clear_logs();

        // Random 8N1 frames against a byte queue
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send(0, b, -1, 1'b1, t);
        end
        idle(5);
        check("rnd0_count", pop0_d.size(), exp_q.size());
        for (int i = 0; i < pop0_d.size() && i < exp_q.size(); i++)
            check($sformatf("rnd0_byte%0d", i), 32'(pop0_d[i]), 32'(exp_q[i]));
        check("rnd0_flags", fe0_q.size() + pe0_q.size() + ov0_q.size(), 0);
        clear_logs();

        // Random parity frames with injected parity and stop errors
        exp_q.delete();
        exp_fe = 0;
        exp_pe = 0;
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom);
            pgood = ($urandom_range(0, 2) != 0);
            sgood = ($urandom_range(0, 3) != 0);
            pbit = (^b) ^ !pgood;
            if (!sgood) exp_fe++;
            else if (!pgood) exp_pe++;
            else exp_q.push_back(b);
            send(1, b, int'(pbit), sgood, t);
            rx1 = 1'b1;
            idle(C);
        end
        idle(5);
        check("rnd1_count", pop1_d.size(), exp_q.size());
        for (int i = 0; i < pop1_d.size() && i < exp_q.size(); i++)
            check($sformatf("rnd1_byte%0d", i), 32'(pop1_d[i]), 32'(exp_q[i]));
        check("rnd1_fe", fe1_q.size(), exp_fe);
        check("rnd1_pe", pe1_q.size(), exp_pe);
        check("rnd1_ov", ov1_q.size(), 0);
        clear_logs();

        // Reset mid-frame: queued byte and partial frame are both lost
        ready0 = 1'b0;
        send(0, 8'h33, -1, 1'b1, t);
        idle(4);
        check("mr_pre_valid", 32'(valid0), 1);
        check("mr_pre_dout", 32'(dout0), 32'h33);
        b = 8'h5A;
        rx0 = 1'b0;
        idle(C);
        for (int i = 0; i < 3; i++) begin
            rx0 = b[i];
            idle(C);
        end
        rx0 = b[3];
        idle(8);
        check("mr_pre_busy", 32'(busy0), 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mr_valid", 32'(valid0), 0);
        check("mr_dout", 32'(dout0), 0);
        check("mr_busy", 32'(busy0), 0);
        check("mr_flags", {29'd0, fe0, pe0, ov0}, 0);
        rx0 = 1'b1;
        ready0 = 1'b1;
        idle(2 * C);
        clear_logs();
        send(0, 8'h5A, -1, 1'b1, t);
        idle(5);
        check("mr_pops", pop0_d.size(), 1);
        if (pop0_d.size() > 0) begin
            check("mr_data", 32'(pop0_d[0]), 32'h5A);
            check("mr_time", pop0_c[0], t + 155);
        end
        check("mr_post_flags", fe0_q.size() + pe0_q.size() + ov0_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
